// File: rtl/icache_param.sv
// icache_param: direct-mapped instruction cache with a blocking, word-serial
// line fill over the memory port, a global invalidate and hit/miss counters.
module icache_param #(
  parameter int SETS  = 16,
  parameter int WORDS = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        inval,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic [31:0] iload,
  input  logic        iwait,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int OFF_BITS = $clog2(WORDS);
  localparam int IDX_BITS = $clog2(SETS);
  localparam int TAG_BITS = 30 - OFF_BITS - IDX_BITS;
  // WORDS=1 has no offset field, but the fill counter still needs one bit.
  localparam int CNT_BITS = (OFF_BITS == 0) ? 1 : OFF_BITS;

  localparam logic [CNT_BITS-1:0] LAST_WORD = CNT_BITS'(WORDS - 1);
  localparam logic [CNT_BITS-1:0] CNT_ZERO  = CNT_BITS'(0);
  localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);
  localparam logic [31:0]         PERF_MAX  = 32'hFFFF_FFFF;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  function automatic logic [CNT_BITS-1:0] addr_offset(input logic [29:0] w);
    return CNT_BITS'(w & 30'(WORDS - 1));
  endfunction

  function automatic logic [IDX_BITS-1:0] addr_index(input logic [29:0] w);
    return IDX_BITS'(w >> OFF_BITS);
  endfunction

  function automatic logic [TAG_BITS-1:0] addr_tag(input logic [29:0] w);
    return TAG_BITS'(w >> (OFF_BITS + IDX_BITS));
  endfunction

  function automatic logic [29:0] fill_word(input logic [TAG_BITS-1:0] t,
                                            input logic [IDX_BITS-1:0] i,
                                            input logic [CNT_BITS-1:0] c);
    return (30'(t) << (IDX_BITS + OFF_BITS)) | (30'(i) << OFF_BITS) |
           (30'(c) & 30'(WORDS - 1));
  endfunction

  logic [0:0]          state_r;
  logic [CNT_BITS-1:0] cnt_r;
  logic [TAG_BITS-1:0] ltag_r;
  logic [IDX_BITS-1:0] lidx_r;
  logic [SETS-1:0]     valid_r;
  logic [TAG_BITS-1:0] tag_mem_r  [SETS];
  logic [31:0]         data_mem_r [SETS][WORDS];
  logic [31:0]         hit_cnt_r;
  logic [31:0]         miss_cnt_r;

  logic [29:0]         word_s;
  logic [CNT_BITS-1:0] off_s;
  logic [IDX_BITS-1:0] idx_s;
  logic [TAG_BITS-1:0] tag_s;
  logic                lookup_s;
  logic                ihit_s;
  logic                accept_s;
  logic                last_s;

  // Address split, tag lookup and the memory-side request.
  always_comb begin
    word_s   = imemaddr[31:2];
    off_s    = addr_offset(word_s);
    idx_s    = addr_index(word_s);
    tag_s    = addr_tag(word_s);
    lookup_s = valid_r[idx_s] && (tag_mem_r[idx_s] == tag_s);
    imemload = data_mem_r[idx_s][off_s];

    if ((state_r == IDLE) && imemREN && !inval && !RST) begin
      ihit_s = lookup_s;
    end else begin
      ihit_s = 1'b0;
    end

    if ((state_r == FILL) && !RST) begin
      iREN  = 1'b1;
      iaddr = {fill_word(ltag_r, lidx_r, cnt_r), 2'b00};
    end else begin
      iREN  = 1'b0;
      iaddr = 32'h0000_0000;
    end

    if ((state_r == FILL) && !RST && !inval && !iwait) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    last_s = (cnt_r == LAST_WORD);
  end

  assign ihit     = ihit_s;
  assign hit_cnt  = hit_cnt_r;
  assign miss_cnt = miss_cnt_r;

  // Control FSM: miss detection, fill sequencing, invalidate and miss counting.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= IDLE;
      cnt_r      <= CNT_ZERO;
      valid_r    <= {SETS{1'b0}};
      miss_cnt_r <= 32'h0000_0000;
    end else if (inval) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      valid_r <= {SETS{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (imemREN && !lookup_s) begin
            state_r <= FILL;
            ltag_r  <= tag_s;
            lidx_r  <= idx_s;
            cnt_r   <= CNT_ZERO;
            if (miss_cnt_r != PERF_MAX) begin
              miss_cnt_r <= miss_cnt_r + 32'd1;
            end
          end
        end
        FILL: begin
          if (!iwait) begin
            if (last_s) begin
              valid_r[lidx_r] <= 1'b1;
              state_r         <= IDLE;
              cnt_r           <= CNT_ZERO;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

  // Data and tag arrays; written only by accepted fill beats, never reset.
  always_ff @(posedge CLK) begin
    if (accept_s) begin
      data_mem_r[lidx_r][cnt_r] <= iload;
      if (last_s) begin
        tag_mem_r[lidx_r] <= ltag_r;
      end
    end
  end

  // Hit counter, saturating.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_cnt_r <= 32'h0000_0000;
    end else if (ihit_s && (hit_cnt_r != PERF_MAX)) begin
      hit_cnt_r <= hit_cnt_r + 32'd1;
    end
  end

endmodule
